// File: rtl/host_bus_if_pkg.sv
`timescale 1ns/1ps
// host_bus_if_pkg: shared constants, default widths and FSM encoding
// for the host-bus to vram bridge.
package host_bus_if_pkg;

    localparam logic BUS_HOST_READ  = 1'b0;
    localparam logic BUS_HOST_WRITE = 1'b1;

    localparam int DEF_ADDR_W      = 11;
    localparam int DEF_DATA_W      = 8;
    localparam int DEF_VRAM_ADDR_W = 13;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        HB_IDLE,
        HB_WR_ISSUE,
        HB_RD_ISSUE,
        HB_RD_WAIT,
        HB_RD_HOLD,
        HB_RELEASE
    } hb_state_e;

    function automatic logic hb_is_issue(
        input hb_state_e s
    );
        return (s == HB_WR_ISSUE) ||
               (s == HB_RD_ISSUE);
    endfunction

endpackage

// File: rtl/host_bus_if_if.sv
`timescale 1ns/1ps
// host_bus_if_if: host pins plus vram host port, seen from the bridge
// (slave) or from the board/model side (master).
interface host_bus_if_if #(
    parameter int ADDR_W      = host_bus_if_pkg::DEF_ADDR_W,
    parameter int DATA_W      = host_bus_if_pkg::DEF_DATA_W,
    parameter int VRAM_ADDR_W = host_bus_if_pkg::DEF_VRAM_ADDR_W
) ();

    localparam int BANK_W = VRAM_ADDR_W - ADDR_W;

    logic [ADDR_W-1:0]      hostBusAddr;
    logic [DATA_W-1:0]      hostBusDataIn;
    logic [DATA_W-1:0]      hostBusDataOut;
    logic                   hostBusDataOe;
    logic                   nHostRMEM;
    logic                   nHostWMEM;
    logic                   nHostVRAMEn;
    logic                   nHostBankRegEn;
    logic                   hostBusDir;

    logic [VRAM_ADDR_W-1:0] hostAddr;
    logic [DATA_W-1:0]      hostWrData;
    logic                   hostSelect;
    logic                   hostRd;
    logic [DATA_W-1:0]      hostRdData;

    logic [BANK_W-1:0]      bank;
    logic                   protoErr;

    modport slave (
        input  hostBusAddr,
        input  hostBusDataIn,
        input  nHostRMEM,
        input  nHostWMEM,
        input  nHostVRAMEn,
        input  nHostBankRegEn,
        input  hostRdData,
        output hostBusDataOut,
        output hostBusDataOe,
        output hostBusDir,
        output hostAddr,
        output hostWrData,
        output hostSelect,
        output hostRd,
        output bank,
        output protoErr
    );

    modport master (
        output hostBusAddr,
        output hostBusDataIn,
        output nHostRMEM,
        output nHostWMEM,
        output nHostVRAMEn,
        output nHostBankRegEn,
        output hostRdData,
        input  hostBusDataOut,
        input  hostBusDataOe,
        input  hostBusDir,
        input  hostAddr,
        input  hostWrData,
        input  hostSelect,
        input  hostRd,
        input  bank,
        input  protoErr
    );

endinterface

// File: rtl/host_bus_if_sync_edge.sv
`timescale 1ns/1ps
// sync_edge: STAGES-deep synchroniser for an active-low async strobe,
// with registered one-cycle falling/rising edge pulses.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o,
    output logic fall_o,
    output logic rise_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic              fall_q;
    logic              rise_q;

    // Reset to 1 so a deasserted strobe never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
            fall_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
            prev_q <= sync_q[STAGES-1];
            fall_q <= prev_q & ~sync_q[STAGES-1];
            rise_q <= ~prev_q & sync_q[STAGES-1];
        end
    end

    assign sync_o = sync_q[STAGES-1];
    assign fall_o = fall_q;
    assign rise_o = rise_q;

endmodule

// File: rtl/host_bus_if.sv
`timescale 1ns/1ps
// host_bus_if: synchronises host memory strobes into the dot-clock domain,
// keeps the bank register and issues single-cycle vram host-port accesses.
module host_bus_if
    import host_bus_if_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int VRAM_ADDR_W = DEF_VRAM_ADDR_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic         clk,
    input  logic         nrst,
    host_bus_if_if.slave bus
);

    localparam int BANK_W = VRAM_ADDR_W - ADDR_W;

    if (BANK_W < 1) begin : g_bad_bank_lo
        $error("host_bus_if: VRAM_ADDR_W must exceed ADDR_W");
    end
    if (BANK_W > DATA_W) begin : g_bad_bank_hi
        $error("host_bus_if: bank wider than data bus");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("host_bus_if: SYNC_STAGES must be >= 2");
    end

    logic r_lvl;
    logic r_fall;
    logic r_rise;
    logic w_lvl;
    logic w_fall;
    logic w_rise;

    sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_rsync (
        .clk    (clk),
        .rst_n  (nrst),
        .async_i(bus.nHostRMEM),
        .sync_o (r_lvl),
        .fall_o (r_fall),
        .rise_o (r_rise)
    );

    sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_wsync (
        .clk    (clk),
        .rst_n  (nrst),
        .async_i(bus.nHostWMEM),
        .sync_o (w_lvl),
        .fall_o (w_fall),
        .rise_o (w_rise)
    );

    hb_state_e              state_q;
    hb_state_e              state_d;
    logic                   vram_q;
    logic                   vram_d;
    logic [VRAM_ADDR_W-1:0] addr_q;
    logic [VRAM_ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0]      wdat_q;
    logic [DATA_W-1:0]      wdat_d;
    logic [BANK_W-1:0]      bdat_q;
    logic [BANK_W-1:0]      bdat_d;
    logic [BANK_W-1:0]      bank_q;
    logic [BANK_W-1:0]      bank_d;
    logic [DATA_W-1:0]      rdat_q;
    logic [DATA_W-1:0]      rdat_d;
    logic                   perr_q;
    logic                   perr_d;

    logic vram_win;
    logic en_ok;
    logic any_fall;
    logic illegal;
    logic r_high;
    logic w_high;

    assign vram_win = ~bus.nHostVRAMEn;
    assign en_ok    = bus.nHostVRAMEn ^ bus.nHostBankRegEn;
    assign any_fall = w_fall | r_fall;
    assign illegal  = (w_fall & r_fall) |
                      (~w_lvl & ~r_lvl) |
                      ~en_ok;

    // A rise pulse counts as "released" even if the level sampled late.
    assign r_high = r_lvl | r_rise;
    assign w_high = w_lvl | w_rise;

    always_comb begin
        state_d = state_q;
        vram_d  = vram_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        bdat_d  = bdat_q;
        bank_d  = bank_q;
        rdat_d  = rdat_q;
        perr_d  = 1'b0;

        unique case (state_q)
            HB_IDLE: begin
                if (any_fall) begin
                    if (illegal) begin
                        perr_d  = 1'b1;
                        state_d = HB_RELEASE;
                    end else begin
                        vram_d = vram_win;
                        if (vram_win) begin
                            addr_d = {bank_q, bus.hostBusAddr};
                        end
                        if (w_fall) begin
                            state_d = HB_WR_ISSUE;
                            if (vram_win) begin
                                wdat_d = bus.hostBusDataIn;
                            end else begin
                                bdat_d = bus.hostBusDataIn[BANK_W-1:0];
                            end
                        end else begin
                            state_d = HB_RD_ISSUE;
                        end
                    end
                end
            end
            HB_WR_ISSUE: begin
                if (!vram_q) begin
                    bank_d = bdat_q;
                end
                state_d = HB_RELEASE;
            end
            HB_RD_ISSUE: begin
                state_d = HB_RD_WAIT;
            end
            HB_RD_WAIT: begin
                rdat_d  = vram_q ? bus.hostRdData
                                 : DATA_W'(bank_q);
                state_d = HB_RD_HOLD;
            end
            HB_RD_HOLD: begin
                if (r_high) begin
                    state_d = HB_IDLE;
                end
            end
            HB_RELEASE: begin
                if (w_high && r_high) begin
                    state_d = HB_IDLE;
                end
            end
            default: begin
                state_d = HB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= HB_IDLE;
            vram_q  <= 1'b0;
            addr_q  <= '0;
            wdat_q  <= '0;
            bdat_q  <= '0;
            bank_q  <= '0;
            rdat_q  <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vram_q  <= vram_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            bdat_q  <= bdat_d;
            bank_q  <= bank_d;
            rdat_q  <= rdat_d;
            perr_q  <= perr_d;
        end
    end

    // Bus controls decode straight from state so reset releases the pad at once.
    assign bus.hostSelect     = vram_q & hb_is_issue(state_q);
    assign bus.hostRd         = (state_q != HB_WR_ISSUE);
    assign bus.hostAddr       = addr_q;
    assign bus.hostWrData     = wdat_q;
    assign bus.hostBusDataOut = rdat_q;
    assign bus.hostBusDataOe  = (state_q == HB_RD_HOLD);
    assign bus.hostBusDir     = (state_q == HB_RD_HOLD) ? BUS_HOST_READ
                                                        : BUS_HOST_WRITE;
    assign bus.bank           = bank_q;
    assign bus.protoErr       = perr_q;

endmodule

// File: tb/tb_host_bus_if.sv
`timescale 1ns/1ps
// tb_host_bus_if: drives host strobes, models vram and checks vram
// accesses against a scoreboard of expected transactions.
module tb_host_bus_if;
    import host_bus_if_pkg::*;

    localparam int AW = 11;
    localparam int DW = 8;
    localparam int VW = 13;
    localparam int SS = 2;
    localparam int BW = VW - AW;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #20 clk = ~clk;

    host_bus_if_if #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .VRAM_ADDR_W(VW)
    ) hb ();

    host_bus_if #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .VRAM_ADDR_W(VW),
        .SYNC_STAGES(SS)
    ) dut (
        .clk (clk),
        .nrst(nrst),
        .bus (hb)
    );

    typedef struct {
        logic [VW-1:0] addr;
        logic [DW-1:0] data;
        logic          rd;
        int            cyc;
    } acc_t;

    acc_t          sb[$];
    acc_t          e;
    int            n_run    = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    int            sel_cnt  = 0;
    int            perr_cnt = 0;
    logic          sel_prev = 1'b0;
    logic          perr_prev = 1'b0;
    logic [BW-1:0] bank_m   = '0;
    logic [DW-1:0] mem [0:(1<<VW)-1];

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // vram model: read data appears the cycle after the select
    always @(posedge clk) begin
        if (hb.hostSelect) begin
            if (hb.hostRd) hb.hostRdData <= mem[hb.hostAddr];
            else           mem[hb.hostAddr] <= hb.hostWrData;
        end
    end

    always @(negedge clk) begin
        if (hb.hostSelect) begin
            sel_cnt++;
            chk("sel_width", {31'd0, sel_prev}, 0);
            chk("sel_expected", {31'd0, sb.size() != 0}, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sel_addr", {19'd0, hb.hostAddr}, {19'd0, e.addr});
                chk("sel_rd", {31'd0, hb.hostRd}, {31'd0, e.rd});
                if (!e.rd)
                    chk("sel_wdata", {24'd0, hb.hostWrData}, {24'd0, e.data});
                chk("sel_latency", cyc, e.cyc);
            end
        end
        sel_prev = hb.hostSelect;
        if (hb.protoErr) begin
            perr_cnt++;
            chk("perr_width", {31'd0, perr_prev}, 0);
        end
        perr_prev = hb.protoErr;
    end

    task automatic idle_pins();
        hb.nHostRMEM      = 1'b1;
        hb.nHostWMEM      = 1'b1;
        hb.nHostVRAMEn    = 1'b1;
        hb.nHostBankRegEn = 1'b1;
    endtask

    task automatic host_wr(input logic [AW-1:0] a,
                           input logic [DW-1:0] d,
                           input logic vram);
        @(negedge clk);
        hb.hostBusAddr    = a;
        hb.hostBusDataIn  = d;
        hb.nHostVRAMEn    = ~vram;
        hb.nHostBankRegEn = vram;
        hb.nHostWMEM      = 1'b0;
        if (vram) sb.push_back('{addr: {bank_m, a}, data: d,
                                 rd: 1'b0, cyc: cyc + SS + 2});
        else      bank_m = d[BW-1:0];
        repeat (5) @(negedge clk);
        idle_pins();
        repeat (4) @(negedge clk);
    endtask

    task automatic host_rd(input string tag,
                           input logic [AW-1:0] a,
                           input logic vram,
                           input logic [DW-1:0] exp_d,
                           input logic release_it);
        int t0;
        int n;
        @(negedge clk);
        hb.hostBusAddr    = a;
        hb.nHostVRAMEn    = ~vram;
        hb.nHostBankRegEn = vram;
        hb.nHostRMEM      = 1'b0;
        t0 = cyc;
        if (vram) sb.push_back('{addr: {bank_m, a}, data: '0,
                                 rd: 1'b1, cyc: cyc + SS + 2});
        n = 0;
        while (!hb.hostBusDataOe && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_oe"}, {31'd0, hb.hostBusDataOe}, 1);
        chk({tag, "_lat"}, cyc - t0, SS + 4);
        chk({tag, "_data"}, {24'd0, hb.hostBusDataOut}, {24'd0, exp_d});
        chk({tag, "_dir"}, {31'd0, hb.hostBusDir}, {31'd0, BUS_HOST_READ});
        repeat (3) @(negedge clk);
        chk({tag, "_hold_oe"}, {31'd0, hb.hostBusDataOe}, 1);
        if (release_it) begin
            idle_pins();
            n = 0;
            while (hb.hostBusDataOe && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk({tag, "_rel_oe"}, {31'd0, hb.hostBusDataOe}, 0);
            chk({tag, "_rel_dir"}, {31'd0, hb.hostBusDir},
                {31'd0, BUS_HOST_WRITE});
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic bad_access(input string tag,
                              input logic nr, input logic nw,
                              input logic nv, input logic nb);
        int p0;
        int s0;
        p0 = perr_cnt;
        s0 = sel_cnt;
        @(negedge clk);
        hb.hostBusAddr    = 11'h0F0;
        hb.hostBusDataIn  = 8'h01;
        hb.nHostVRAMEn    = nv;
        hb.nHostBankRegEn = nb;
        hb.nHostRMEM      = nr;
        hb.nHostWMEM      = nw;
        repeat (8) @(negedge clk);
        idle_pins();
        repeat (6) @(negedge clk);
        chk({tag, "_perr"}, perr_cnt - p0, 1);
        chk({tag, "_nosel"}, sel_cnt - s0, 0);
        chk({tag, "_bank"}, {30'd0, hb.bank}, {30'd0, bank_m});
        chk({tag, "_oe"}, {31'd0, hb.hostBusDataOe}, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        idle_pins();
        hb.hostBusAddr   = '0;
        hb.hostBusDataIn = '0;
        repeat (3) @(negedge clk);
        chk("rst_sel", {31'd0, hb.hostSelect}, 0);
        chk("rst_rd", {31'd0, hb.hostRd}, 1);
        chk("rst_addr", {19'd0, hb.hostAddr}, 0);
        chk("rst_wdata", {24'd0, hb.hostWrData}, 0);
        chk("rst_dout", {24'd0, hb.hostBusDataOut}, 0);
        chk("rst_oe", {31'd0, hb.hostBusDataOe}, 0);
        chk("rst_dir", {31'd0, hb.hostBusDir}, {31'd0, BUS_HOST_WRITE});
        chk("rst_bank", {30'd0, hb.bank}, 0);
        chk("rst_perr", {31'd0, hb.protoErr}, 0);
        nrst = 1'b1;
        repeat (3) @(negedge clk);

        host_wr(11'h000, 8'h02, 1'b0);
        chk("bank_wr2", {30'd0, hb.bank}, 2);
        s0 = sel_cnt;
        host_wr(11'h155, 8'hA5, 1'b1);
        chk("vwr_one_sel", sel_cnt - s0, 1);

        host_wr(11'h155, 8'h3C, 1'b1);
        host_rd("vrd", 11'h155, 1'b1, 8'h3C, 1'b1);

        host_wr(11'h000, 8'h03, 1'b0);
        chk("bank_wr3", {30'd0, hb.bank}, 3);
        s0 = sel_cnt;
        host_rd("bankrd", 11'h000, 1'b0, 8'h03, 1'b1);
        chk("bankrd_nosel", sel_cnt - s0, 0);

        bad_access("both_str", 1'b0, 1'b0, 1'b0, 1'b1);
        bad_access("both_en", 1'b1, 1'b0, 1'b0, 1'b0);
        bad_access("no_en", 1'b0, 1'b1, 1'b1, 1'b1);

        s0 = sel_cnt;
        for (int i = 0; i < 64; i++) begin
            host_wr(AW'($urandom_range(0, (1<<AW)-1)),
                    DW'($urandom_range(0, 255)), 1'b1);
        end
        repeat (6) @(negedge clk);
        chk("rand_sel_cnt", sel_cnt - s0, 64);
        chk("rand_sb_empty", sb.size(), 0);

        host_wr(11'h0AA, 8'h77, 1'b1);
        host_rd("prerst", 11'h0AA, 1'b1, 8'h77, 1'b0);
        #5;
        nrst = 1'b0;
        #1;
        chk("arst_oe", {31'd0, hb.hostBusDataOe}, 0);
        chk("arst_dir", {31'd0, hb.hostBusDir}, {31'd0, BUS_HOST_WRITE});
        chk("arst_bank", {30'd0, hb.bank}, 0);
        idle_pins();
        bank_m = '0;
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        repeat (3) @(negedge clk);
        host_rd("postrst", 11'h000, 1'b0, 8'h00, 1'b1);
        chk("end_sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
